mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_unit_pkg.sv | 30 +++
 rtl/mem_access_unit_load_aligner.sv | 32 +++
 rtl/mem_access_unit.sv | 189 ++++++++++++++++++
 tb/tb_mem_access_unit.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_unit_pkg.sv
// Shared types and constants for the MEM-stage data memory access unit.
// States, access size codes and default widths used by the unit and its aligner.
package mem_access_unit_pkg;

   localparam int MAU_WIDTH   = 32;
   localparam int MAU_TIMEOUT = 255;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_BUSY = 2'b01,
      S_DONE = 2'b10
   } mau_state_e;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   // Natural alignment rule; size 11 behaves as a word.
   function automatic logic is_misaligned(
      input logic [1:0] size,
      input logic [1:0] off
   );
      case (size)
         SZ_BYTE: return 1'b0;
         SZ_HALF: return off[0];
         default: return |off;
      endcase
   endfunction

endpackage

// File: rtl/mem_access_unit_load_aligner.sv
// Load lane select and sign/zero extension for sub-word loads.
// Only present when MEM_SUBWORD_EN is defined.
`ifdef MEM_SUBWORD_EN
module load_aligner
   import mem_access_unit_pkg::*;
#(
   parameter int WIDTH = MAU_WIDTH
) (
   input  logic [1:0]       off_i,
   input  logic [1:0]       size_i,
   input  logic             uns_i,
   input  logic [WIDTH-1:0] rdata_i,
   output logic [WIDTH-1:0] data_o
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   // Pick the addressed lane and extend it to the full datapath.
   always_comb begin
      byte_sel = rdata_i[{off_i, 3'b000} +: 8];
      half_sel = off_i[1] ? rdata_i[16 +: 16] : rdata_i[0 +: 16];
      data_o   = rdata_i;
      unique case (size_i)
         SZ_BYTE: data_o = {{(WIDTH-8){byte_sel[7] & ~uns_i}}, byte_sel};
         SZ_HALF: data_o = {{(WIDTH-16){half_sel[15] & ~uns_i}}, half_sel};
         default: data_o = rdata_i;
      endcase
   end

endmodule
`endif

// File: rtl/mem_access_unit.sv
// MEM-stage data memory access unit: IDLE/BUSY/DONE handshake with timeout.
// MEM_SUBWORD_EN enables byte/half accesses; otherwise every access is a word.
module mem_access_unit
   import mem_access_unit_pkg::*;
#(
   parameter int WIDTH          = MAU_WIDTH,
   parameter int TIMEOUT_CYCLES = MAU_TIMEOUT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             memread_mem,
   input  logic             memwrite_mem,
   input  logic [1:0]       size_mem,
   input  logic             unsigned_mem,
   input  logic [WIDTH-1:0] aluout_mem,
   input  logic [WIDTH-1:0] writedata_mem,
   output logic [WIDTH-1:0] readdata_mem,
   output logic             stall_mem,
   output logic             misalign_mem,
   output logic             buserr_mem,
   output logic             dmem_req,
   output logic             dmem_we,
   output logic [WIDTH-1:0] dmem_addr,
   output logic [WIDTH-1:0] dmem_wdata,
   output logic [3:0]       dmem_be,
   input  logic             dmem_ack,
   input  logic [WIDTH-1:0] dmem_rdata
);

   localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

   mau_state_e       state_q, state_d;
   logic [7:0]       cnt_q, cnt_d;
   logic [WIDTH-1:0] addr_q, addr_d;
   logic [WIDTH-1:0] wdata_q, wdata_d;
   logic [WIDTH-1:0] rdata_q, rdata_d;
   logic [3:0]       be_q, be_d;
   logic             we_q, we_d;
   logic             buserr_q, buserr_d;

   logic             req_any;
   logic             in_idle;
   logic             in_busy;
   logic             misalign;
   logic             access;
   logic [3:0]       be_new;
   logic [WIDTH-1:0] wdata_new;
   logic [WIDTH-1:0] load_data;

`ifdef MEM_SUBWORD_EN
   logic [1:0]       size_q, size_d;
   logic             uns_q, uns_d;

   // Store lane steering and byte enables from size and address offset.
   always_comb begin
      be_new    = 4'b1111;
      wdata_new = writedata_mem;
      unique case (size_mem)
         SZ_BYTE: begin
            be_new    = 4'b0001 << aluout_mem[1:0];
            wdata_new = {(WIDTH/8){writedata_mem[7:0]}};
         end
         SZ_HALF: begin
            be_new    = aluout_mem[1] ? 4'b1100 : 4'b0011;
            wdata_new = {(WIDTH/16){writedata_mem[15:0]}};
         end
         default: ;
      endcase
   end

   assign misalign = is_misaligned(size_mem, aluout_mem[1:0]);

   load_aligner #(
      .WIDTH (WIDTH)
   ) u_load_aligner (
      .off_i   (addr_q[1:0]),
      .size_i  (size_q),
      .uns_i   (uns_q),
      .rdata_i (dmem_rdata),
      .data_o  (load_data)
   );
`else
   logic unused_cfg;

   assign be_new     = 4'b1111;
   assign wdata_new  = writedata_mem;
   assign misalign   = |aluout_mem[1:0];
   assign load_data  = dmem_rdata;
   assign unused_cfg = ^{size_mem, unsigned_mem, addr_q[1:0]};
`endif

   assign req_any = rst & (memread_mem | memwrite_mem);
   assign in_idle = (state_q == S_IDLE);
   assign in_busy = (state_q == S_BUSY);
   assign access  = in_idle & req_any & ~misalign;

   // Next-state, latch and result logic of the access FSM.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      be_d     = be_q;
      we_d     = we_q;
      rdata_d  = rdata_q;
      buserr_d = buserr_q;
`ifdef MEM_SUBWORD_EN
      size_d   = size_q;
      uns_d    = uns_q;
`endif
      unique case (state_q)
         S_IDLE: begin
            if (access) begin
               state_d = S_BUSY;
               cnt_d   = '0;
               addr_d  = aluout_mem;
               wdata_d = wdata_new;
               be_d    = be_new;
               we_d    = memwrite_mem;
`ifdef MEM_SUBWORD_EN
               size_d  = size_mem;
               uns_d   = unsigned_mem;
`endif
            end
         end
         S_BUSY: begin
            if (dmem_ack) begin
               state_d  = S_DONE;
               rdata_d  = we_q ? '0 : load_data;
               buserr_d = 1'b0;
            end else if (cnt_q == TO_LAST) begin
               state_d  = S_DONE;
               rdata_d  = '0;
               buserr_d = 1'b1;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         S_DONE: begin
            state_d  = S_IDLE;
            rdata_d  = '0;
            buserr_d = 1'b0;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State register with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         addr_q   <= '0;
         wdata_q  <= '0;
         be_q     <= '0;
         we_q     <= 1'b0;
         rdata_q  <= '0;
         buserr_q <= 1'b0;
`ifdef MEM_SUBWORD_EN
         size_q   <= '0;
         uns_q    <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         be_q     <= be_d;
         we_q     <= we_d;
         rdata_q  <= rdata_d;
         buserr_q <= buserr_d;
`ifdef MEM_SUBWORD_EN
         size_q   <= size_d;
         uns_q    <= uns_d;
`endif
      end
   end

   assign stall_mem    = access | in_busy;
   assign misalign_mem = in_idle & req_any & misalign;
   assign readdata_mem = rdata_q;
   assign buserr_mem   = buserr_q;
   assign dmem_req     = in_busy;
   assign dmem_we      = in_busy & we_q;
   assign dmem_addr    = in_busy ? {addr_q[WIDTH-1:2], 2'b00} : '0;
   assign dmem_wdata   = in_busy ? wdata_q : '0;
   assign dmem_be      = in_busy ? be_q : 4'b0000;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit (TIMEOUT_CYCLES=4).
// Works for both builds; MEM_SUBWORD_EN selects sub-word expectations.
module tb_mem_access_unit;

   localparam int TO = 4;

`ifdef MEM_SUBWORD_EN
   localparam bit SUBWORD = 1'b1;
`else
   localparam bit SUBWORD = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        memread_mem = 1'b0;
   logic        memwrite_mem = 1'b0;
   logic [1:0]  size_mem = 2'b10;
   logic        unsigned_mem = 1'b0;
   logic [31:0] aluout_mem = '0;
   logic [31:0] writedata_mem = '0;
   logic [31:0] readdata_mem;
   logic        stall_mem;
   logic        misalign_mem;
   logic        buserr_mem;
   logic        dmem_req;
   logic        dmem_we;
   logic [31:0] dmem_addr;
   logic [31:0] dmem_wdata;
   logic [3:0]  dmem_be;
   logic        dmem_ack = 1'b0;
   logic [31:0] dmem_rdata = '0;

   int n_checks = 0;
   int n_fail   = 0;
   bit model_on = 1'b0;

   always #5 clk = ~clk;

   mem_access_unit #(
      .WIDTH          (32),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .memread_mem   (memread_mem),
      .memwrite_mem  (memwrite_mem),
      .size_mem      (size_mem),
      .unsigned_mem  (unsigned_mem),
      .aluout_mem    (aluout_mem),
      .writedata_mem (writedata_mem),
      .readdata_mem  (readdata_mem),
      .stall_mem     (stall_mem),
      .misalign_mem  (misalign_mem),
      .buserr_mem    (buserr_mem),
      .dmem_req      (dmem_req),
      .dmem_we       (dmem_we),
      .dmem_addr     (dmem_addr),
      .dmem_wdata    (dmem_wdata),
      .dmem_be       (dmem_be),
      .dmem_ack      (dmem_ack),
      .dmem_rdata    (dmem_rdata)
   );

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic chkb(input string name, input logic act, input logic exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b, expected %b", name, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic logic [1:0] eff_size(input logic [1:0] s);
      if (!SUBWORD) return 2'd2;
      return (s == 2'd3) ? 2'd2 : s;
   endfunction

   function automatic bit mis_model(input logic [1:0] s, input logic [31:0] a);
      case (eff_size(s))
         2'd0:    return 1'b0;
         2'd1:    return (a % 2) != 0;
         default: return (a % 4) != 0;
      endcase
   endfunction

   function automatic logic [3:0] exp_be(input logic [1:0] s,
                                         input logic [31:0] a);
      logic [3:0] one;
      one = 4'b0001;
      case (eff_size(s))
         2'd0:    return one << (a % 4);
         2'd1:    return ((a % 4) >= 2) ? 4'hC : 4'h3;
         default: return 4'hF;
      endcase
   endfunction

   function automatic logic [31:0] exp_wd(input logic [1:0] s,
                                          input logic [31:0] wd);
      case (eff_size(s))
         2'd0:    return (wd % 256) * 32'h01010101;
         2'd1:    return (wd % 65536) * 32'h00010001;
         default: return wd;
      endcase
   endfunction

   function automatic logic [31:0] exp_load(input logic [31:0] rd,
                                            input logic [31:0] a,
                                            input logic [1:0] s,
                                            input logic u);
      logic [31:0] v;
      case (eff_size(s))
         2'd0: begin
            v = (rd >> (8 * (a % 4))) % 256;
            if (!u && v >= 128) v = v + 32'hFFFFFF00;
         end
         2'd1: begin
            v = (rd >> (8 * (a % 4))) % 65536;
            if (!u && v >= 32768) v = v + 32'hFFFF0000;
         end
         default: v = rd;
      endcase
      return v;
   endfunction

   bit          m_busy = 0;
   bit          m_done = 0;
   int          m_cnt  = 0;
   logic [31:0] m_addr = '0;
   logic [31:0] m_wd   = '0;
   logic [1:0]  m_size = '0;
   logic        m_uns  = 0;
   logic        m_we   = 0;
   logic [31:0] m_res  = '0;
   logic        m_berr = 0;

   // Compare DUT outputs against the model every cycle, then advance it.
   always @(negedge clk) begin
      if (model_on) begin
         logic e_req, e_stall, e_mis, e_berr, any;
         logic [31:0] e_rd;
         e_req = 0; e_stall = 0; e_mis = 0; e_berr = 0; e_rd = '0;
         if (m_done) begin
            e_rd   = m_res;
            e_berr = m_berr;
         end else if (m_busy) begin
            e_req   = 1;
            e_stall = 1;
            chkb("m_we", dmem_we, m_we);
            chk("m_addr", dmem_addr, m_addr & 32'hFFFFFFFC);
            chk("m_be", 32'(dmem_be), 32'(exp_be(m_size, m_addr)));
            chk("m_wdata", dmem_wdata, exp_wd(m_size, m_wd));
         end else begin
            any     = memread_mem || memwrite_mem;
            e_mis   = any && mis_model(size_mem, aluout_mem);
            e_stall = any && !e_mis;
         end
         chkb("m_req", dmem_req, e_req);
         chkb("m_stall", stall_mem, e_stall);
         chkb("m_misalign", misalign_mem, e_mis);
         chkb("m_buserr", buserr_mem, e_berr);
         chk("m_readdata", readdata_mem, e_rd);

         if (!rst) begin
            m_busy = 0;
            m_done = 0;
         end else if (m_done) begin
            m_done = 0;
         end else if (m_busy) begin
            m_cnt++;
            if (dmem_ack) begin
               m_busy = 0; m_done = 1; m_berr = 0;
               m_res = m_we ? '0 : exp_load(dmem_rdata, m_addr, m_size, m_uns);
            end else if (m_cnt >= TO) begin
               m_busy = 0; m_done = 1; m_berr = 1; m_res = '0;
            end
         end else if ((memread_mem || memwrite_mem) &&
                      !mis_model(size_mem, aluout_mem)) begin
            m_busy = 1; m_cnt = 0;
            m_addr = aluout_mem; m_wd = writedata_mem;
            m_size = size_mem; m_uns = unsigned_mem;
            m_we = memwrite_mem;
         end
      end
   end

   // ---------------- directed stimulus ----------------
   typedef struct {
      int          stalls;
      int          busy;
      logic [31:0] res;
      logic        berr;
      logic        mis;
      logic        seen;
      logic        we;
      logic [31:0] addr;
      logic [31:0] wd;
      logic [3:0]  be;
   } res_t;

   task automatic do_access(input bit rd, input bit wr, input logic [1:0] sz,
                            input bit un, input logic [31:0] a,
                            input logic [31:0] wd, input int ack_at,
                            input logic [31:0] rdat, output res_t o);
      int busy;
      bit fin;
      busy = 0; fin = 0;
      o.stalls = 0; o.busy = 0; o.res = '0; o.berr = 0; o.mis = 0;
      o.seen = 0; o.we = 0; o.addr = '0; o.wd = '0; o.be = '0;
      memread_mem = rd; memwrite_mem = wr; size_mem = sz;
      unsigned_mem = un; aluout_mem = a; writedata_mem = wd;
      for (int c = 0; c < 40 && !fin; c++) begin
         if (dmem_req) begin
            dmem_ack   = (busy == ack_at);
            dmem_rdata = rdat;
            busy++;
         end else begin
            dmem_ack = 1'b0;
         end
         @(negedge clk);
         if (dmem_req && !o.seen) begin
            o.seen = 1; o.addr = dmem_addr; o.be = dmem_be;
            o.wd = dmem_wdata; o.we = dmem_we;
         end
         if (stall_mem) o.stalls++;
         else begin
            fin = 1; o.res = readdata_mem;
            o.berr = buserr_mem; o.mis = misalign_mem;
         end
         @(posedge clk); #1;
      end
      o.busy = busy;
      if (!fin) chkb("access_bound", 1'b0, 1'b1);
      memread_mem = 0; memwrite_mem = 0; dmem_ack = 0;
   endtask

   initial begin
      res_t o;
      rst = 1'b0;
      @(posedge clk); #1;
      model_on = 1'b1;
      @(negedge clk);
      chk("rst_readdata", readdata_mem, 32'h0);
      chkb("rst_stall", stall_mem, 1'b0);
      chkb("rst_req", dmem_req, 1'b0);
      chkb("rst_buserr", buserr_mem, 1'b0);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;

      do_access(1, 0, 2'b10, 0, 32'h100, 0, 0, 32'hDEADBEEF, o);
      chk("word_ld_data", o.res, 32'hDEADBEEF);
      chk("word_ld_stalls", o.stalls, 2);
      chk("word_ld_addr", o.addr, 32'h100);

      do_access(1, 0, 2'b00, 0, 32'h103, 0, 0, 32'h80112233, o);
`ifdef MEM_SUBWORD_EN
      chk("byte_ld_signed", o.res, 32'hFFFFFF80);
`else
      chkb("byte_ld_mis", o.mis, 1'b1);
`endif
      do_access(1, 0, 2'b00, 1, 32'h103, 0, 0, 32'h80112233, o);
`ifdef MEM_SUBWORD_EN
      chk("byte_ld_unsigned", o.res, 32'h00000080);
`else
      chkb("byte_ld_u_seen", o.seen, 1'b0);
`endif

      do_access(0, 1, 2'b01, 0, 32'h202, 32'h0000ABCD, 0, 0, o);
`ifdef MEM_SUBWORD_EN
      chk("half_st_addr", o.addr, 32'h200);
      chk("half_st_be", 32'(o.be), 32'hC);
      chk("half_st_wdata", o.wd, 32'hABCDABCD);
      chkb("half_st_we", o.we, 1'b1);
`else
      chkb("half_st_mis", o.mis, 1'b1);
`endif

      do_access(1, 0, 2'b10, 0, 32'h102, 0, 0, 32'h1, o);
      chkb("mis_flag", o.mis, 1'b1);
      chkb("mis_no_req", o.seen, 1'b0);
      chk("mis_stalls", o.stalls, 0);
      chk("mis_readdata", o.res, 32'h0);

      do_access(1, 0, 2'b10, 0, 32'h500, 0, -1, 0, o);
      chk("to_busy_cycles", o.busy, TO);
      chk("to_stalls", o.stalls, TO + 1);
      chkb("to_buserr", o.berr, 1'b1);
      chk("to_readdata", o.res, 32'h0);

      do_access(1, 1, 2'b10, 0, 32'h300, 32'h11223344, 1, 32'hCAFEF00D, o);
      chk("rdwr_readdata", o.res, 32'h0);
      chkb("rdwr_we", o.we, 1'b1);
      chk("rdwr_wdata", o.wd, 32'h11223344);
      chk("rdwr_stalls", o.stalls, 3);

      do_access(0, 1, 2'b10, 0, 32'h40, 32'h01020304, 0, 0, o);
      chk("word_st_be", 32'(o.be), 32'hF);

      do_access(0, 1, 2'b00, 0, 32'h101, 32'h000000A5, 0, 0, o);
`ifdef MEM_SUBWORD_EN
      chk("byte_st_be", 32'(o.be), 32'h2);
      chk("byte_st_wdata", o.wd, 32'hA5A5A5A5);
`else
      chkb("byte_st_mis", o.mis, 1'b1);
`endif
      do_access(1, 0, 2'b01, 0, 32'h100, 0, 0, 32'h12348765, o);
      do_access(1, 0, 2'b01, 1, 32'h102, 0, 0, 32'h80017FFF, o);
`ifdef MEM_SUBWORD_EN
      chk("half_ld_unsigned", o.res, 32'h00008001);
`endif
      do_access(1, 0, 2'b11, 0, 32'h104, 0, 2, 32'h89ABCDEF, o);
      do_access(1, 0, 2'b01, 0, 32'h101, 0, 0, 32'h1, o);

      dmem_ack = 1'b1; dmem_rdata = 32'h55AA55AA;
      repeat (2) begin
         @(negedge clk);
         chk("idle_ack_ignored", readdata_mem, 32'h0);
         @(posedge clk); #1;
      end
      dmem_ack = 1'b0;

      memread_mem = 1; size_mem = 2'b10; aluout_mem = 32'h400;
      @(posedge clk); #1;
      @(negedge clk);
      chkb("rstb_req_before", dmem_req, 1'b1);
      @(posedge clk); #1;
      rst = 1'b0; memread_mem = 0;
      @(posedge clk); #1;
      rst = 1'b1; dmem_ack = 1'b1; dmem_rdata = 32'h12345678;
      @(negedge clk);
      chkb("rstb_req_after", dmem_req, 1'b0);
      chkb("rstb_stall_after", stall_mem, 1'b0);
      @(posedge clk); #1;
      dmem_ack = 1'b0;
      @(negedge clk);
      chk("rstb_late_ack", readdata_mem, 32'h0);
      chkb("rstb_buserr", buserr_mem, 1'b0);
      @(posedge clk); #1;

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

endmodule
